// File: rtl/reg_bank.sv
// reg_bank: assembles byte writes from the command decoder into atomically
// committed 32-bit configuration registers, with an optional readback
// serializer built when REG_BANK_READBACK_EN is defined.
module reg_bank #(
  parameter int          NREGS       = 16,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_stb,
  input  logic [7:0]            wr_addr,
  input  logic [7:0]            wr_data,
  output logic [32*NREGS-1:0]   regs_out,
  output logic [NREGS-1:0]      commit_stb,
  output logic [7:0]            reply_data,
  output logic                  reply_valid,
  input  logic                  reply_ready,
  output logic                  busy,
  output logic                  rb_overrun
);

  localparam logic [6:0] NREGS_L = 7'(NREGS);

  logic [5:0]  wr_idx;
  logic [1:0]  wr_lane;
  logic        shadow_en;
  logic        commit_en;
  logic [23:0] shadow;
  logic [31:0] regs [NREGS];

  assign wr_idx    = wr_addr[7:2];
  assign wr_lane   = wr_addr[1:0];
  // Lane-3 addresses never touch the shadow, which also covers 0xFF.
  assign shadow_en = wr_stb && (wr_lane != 2'd3);
  assign commit_en = wr_stb && (wr_lane == 2'd3) && ({1'b0, wr_idx} < NREGS_L);

  // Shared staging bytes for the low three lanes; kept across commits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= '0;
    end else if (shadow_en) begin
      case (wr_lane)
        2'd0:    shadow[7:0]   <= wr_data;
        2'd1:    shadow[15:8]  <= wr_data;
        default: shadow[23:16] <= wr_data;
      endcase
    end
  end

  // Atomic 32-bit commit on a valid lane-3 write, with a one-cycle pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NREGS; k++) regs[k] <= RESET_VALUE;
      commit_stb <= '0;
    end else begin
      for (int k = 0; k < NREGS; k++) begin
        commit_stb[k] <= commit_en && (wr_idx == 6'(k));
        if (commit_en && (wr_idx == 6'(k))) regs[k] <= {wr_data, shadow};
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_out
    assign regs_out[32*g +: 32] = regs[g];
  end

`ifdef REG_BANK_READBACK_EN
  typedef enum logic {RB_IDLE, RB_SEND} rb_state_t;

  rb_state_t   rb_state;
  logic [31:0] snap;
  logic [1:0]  cnt;
  logic        rb_req;
  logic [31:0] rb_sel;

  assign rb_req = wr_stb && (wr_addr == 8'hFF);

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  // Requested register, or zero for an out-of-range index.
  always_comb begin
    rb_sel = '0;
    for (int k = 0; k < NREGS; k++)
      if (wr_data == 8'(k)) rb_sel = regs[k];
  end

  // Readback serializer: snapshot on request, then stream 4 bytes LSB first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rb_state    <= RB_IDLE;
      snap        <= '0;
      cnt         <= '0;
      reply_valid <= 1'b0;
      reply_data  <= '0;
      busy        <= 1'b0;
      rb_overrun  <= 1'b0;
    end else begin
      rb_overrun <= 1'b0;
      case (rb_state)
        RB_IDLE: begin
          if (rb_req) begin
            snap        <= rb_sel;
            cnt         <= '0;
            reply_data  <= rb_sel[7:0];
            reply_valid <= 1'b1;
            busy        <= 1'b1;
            rb_state    <= RB_SEND;
          end
        end
        RB_SEND: begin
          rb_overrun <= rb_req;
          if (reply_ready) begin
            if (cnt == 2'd3) begin
              cnt         <= '0;
              reply_valid <= 1'b0;
              busy        <= 1'b0;
              rb_state    <= RB_IDLE;
            end else begin
              cnt        <= cnt + 2'd1;
              reply_data <= byte_of(snap, cnt + 2'd1);
            end
          end
        end
        default: rb_state <= RB_IDLE;
      endcase
    end
  end
`else
  logic unused_reply_ready;
  assign unused_reply_ready = reply_ready;
  assign reply_data  = 8'h00;
  assign reply_valid = 1'b0;
  assign busy        = 1'b0;
  assign rb_overrun  = 1'b0;
`endif

endmodule

// File: tb/tb_reg_bank.sv
// Testbench for reg_bank: directed steps plus random traffic checked against
// a transaction-level model of the register file and the readback stream.
module tb_reg_bank;

  localparam int          NREGS = 16;
  localparam logic [31:0] RV    = 32'h0000_0000;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 wr_stb;
  logic [7:0]           wr_addr;
  logic [7:0]           wr_data;
  logic [32*NREGS-1:0]  regs_out;
  logic [NREGS-1:0]     commit_stb;
  logic [7:0]           reply_data;
  logic                 reply_valid;
  logic                 reply_ready;
  logic                 busy;
  logic                 rb_overrun;

  reg_bank #(.NREGS(NREGS), .RESET_VALUE(RV)) dut (
    .clk(clk), .reset_n(reset_n), .wr_stb(wr_stb), .wr_addr(wr_addr),
    .wr_data(wr_data), .regs_out(regs_out), .commit_stb(commit_stb),
    .reply_data(reply_data), .reply_valid(reply_valid),
    .reply_ready(reply_ready), .busy(busy), .rb_overrun(rb_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [31:0]      m_regs [NREGS];
  logic [23:0]      m_shadow;
  logic [NREGS-1:0] m_cstb;
  bit               m_act;
  int               m_pos;
  logic [31:0]      m_snap;
  bit               m_ovr;
  logic [7:0]       rx [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NREGS; k++) m_regs[k] = RV;
    m_shadow = '0;
    m_cstb   = '0;
    m_act    = 0;
    m_pos    = 0;
    m_snap   = '0;
    m_ovr    = 0;
  endtask

  task automatic check_all(input string where);
    for (int k = 0; k < NREGS; k++)
      chk($sformatf("%s reg%0d", where, k), regs_out[32*k +: 32], m_regs[k]);
    chk({where, " commit_stb"}, commit_stb, m_cstb);
    chk({where, " reply_valid"}, reply_valid, m_act);
    chk({where, " busy"}, busy, m_act);
    chk({where, " rb_overrun"}, rb_overrun, m_ovr);
`ifdef REG_BANK_READBACK_EN
    if (m_act) chk({where, " reply_data"}, reply_data, 8'(m_snap >> (8 * m_pos)));
`else
    chk({where, " reply_data"}, reply_data, 8'h00);
`endif
  endtask

  // One clock: drive a (possibly idle) write plus reply_ready, advance model, check.
  task automatic step(input string where, input bit stb, input logic [7:0] a,
                      input logic [7:0] d, input bit rdy);
    bit         req;
    int         idx;
    int         ln;
    wr_stb = stb; wr_addr = a; wr_data = d; reply_ready = rdy;
    #1;
    if (reply_valid && reply_ready) rx.push_back(reply_data);
    idx = int'(a[7:2]);
    ln  = int'(a[1:0]);
    req = stb && (a == 8'hFF);
    m_cstb = '0;
    m_ovr  = 0;
`ifdef REG_BANK_READBACK_EN
    if (m_act) begin
      if (req) m_ovr = 1;
      if (rdy) begin
        if (m_pos == 3) m_act = 0;
        else m_pos++;
      end
    end else if (req) begin
      m_snap = (int'(d) < NREGS) ? m_regs[int'(d)] : 32'h0;
      m_pos  = 0;
      m_act  = 1;
    end
`endif
    if (stb && ln != 3) m_shadow[ln*8 +: 8] = d;
    if (stb && ln == 3 && idx < NREGS) begin
      m_regs[idx] = {d, m_shadow};
      m_cstb[idx] = 1'b1;
    end
    @(posedge clk); #1;
    wr_stb = 1'b0; wr_addr = 8'($urandom); wr_data = 8'($urandom);
    check_all(where);
  endtask

  task automatic do_reset(input string where);
    reset_n = 1'b0;
    #2;
    model_reset();
    check_all({where, " in_reset"});
    @(posedge clk); #1;
    reset_n = 1'b1;
    check_all({where, " released"});
  endtask

  initial begin
    int r;
    reset_n = 1'b0; wr_stb = 1'b0; wr_addr = '0; wr_data = '0; reply_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset reply_data", reply_data, 8'h00);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_all("post_reset");

    // atomic commit
    step("w08", 1, 8'h08, 8'h11, 0);
    step("w09", 1, 8'h09, 8'h22, 0);
    step("w0A", 1, 8'h0A, 8'h33, 0);
    chk("pre_commit reg2", regs_out[95:64], RV);
    step("w0B", 1, 8'h0B, 8'h44, 0);
    chk("commit reg2", regs_out[95:64], 32'h4433_2211);
    chk("commit pulse", commit_stb, 16'h0004);
    step("idle1", 0, 8'h00, 8'h00, 0);
    chk("commit pulse gone", commit_stb, 16'h0000);

    // invalid index keeps shadow
    step("w43", 1, 8'h43, 8'hAA, 0);
    step("wFE", 1, 8'hFE, 8'h33, 0);
    step("w07", 1, 8'h07, 8'hBB, 0);
    chk("reg1 after invalid", regs_out[63:32], 32'hBB33_2211);

    // readback of register 2 with a stall
    rx.delete();
    step("rb_req", 1, 8'hFF, 8'h02, 0);
    step("rb_c0", 0, 8'h00, 8'h00, 1);
    step("rb_c1", 0, 8'h00, 8'h00, 0);
    step("rb_c2", 0, 8'h00, 8'h00, 1);
    step("rb_c3", 0, 8'h00, 8'h00, 1);
    step("rb_c4", 0, 8'h00, 8'h00, 1);
    step("rb_c5", 0, 8'h00, 8'h00, 1);
`ifdef REG_BANK_READBACK_EN
    chk("rb count", rx.size(), 4);
    if (rx.size() == 4) begin
      chk("rb byte0", rx[0], 8'h11);
      chk("rb byte1", rx[1], 8'h22);
      chk("rb byte2", rx[2], 8'h33);
      chk("rb byte3", rx[3], 8'h44);
    end
`else
    chk("rb disabled count", rx.size(), 0);
`endif

    // overrun and snapshot isolation
    rx.delete();
    step("ov_req", 1, 8'hFF, 8'h02, 0);
    step("ov_b0", 0, 8'h00, 8'h00, 1);
    step("ov_req2", 1, 8'hFF, 8'h01, 0);
    step("ov_w0", 1, 8'h08, 8'hA0, 1);
    step("ov_w1", 1, 8'h09, 8'hA1, 0);
    step("ov_w2", 1, 8'h0A, 8'hA2, 1);
    step("ov_w3", 1, 8'h0B, 8'hA3, 0);
    step("ov_last", 1, 8'hFF, 8'h01, 1);
    step("ov_after", 1, 8'hFF, 8'h05, 0);
`ifdef REG_BANK_READBACK_EN
    chk("ov count", rx.size(), 4);
    if (rx.size() == 4) begin
      chk("ov byte2", rx[2], 8'h33);
      chk("ov byte3", rx[3], 8'h44);
    end
`endif
    repeat (5) step("ov_drain", 0, 8'h00, 8'h00, 1);

    // reset mid-transfer after byte 1
    rx.delete();
    step("mr_req", 1, 8'hFF, 8'h02, 0);
    step("mr_b0", 0, 8'h00, 8'h00, 1);
    step("mr_b1", 0, 8'h00, 8'h00, 1);
    do_reset("midreset");
    repeat (4) step("mr_after", 0, 8'h00, 8'h00, 1);
`ifdef REG_BANK_READBACK_EN
    chk("mr bytes", rx.size(), 2);
`else
    chk("mr bytes", rx.size(), 0);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5)
        step("rnd_w", 1, {6'($urandom_range(0, NREGS + 1)), 2'($urandom)}, 8'($urandom), 1'($urandom));
      else if (r == 6)
        step("rnd_rb", 1, 8'hFF, 8'($urandom_range(0, 20)), 1'($urandom));
      else if (r == 7)
        step("rnd_any", 1, 8'($urandom), 8'($urandom), 1'($urandom));
      else
        step("rnd_idle", 0, 8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
